// File: rtl/crc32_pkg.sv
// Shared CRC-32/MPEG-2 constants and the single-bit update step.
// The serial generator and this checker both build on these definitions.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'h00000000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } rx_state_e;

    // One MSB-first shift of the CRC register with the incoming bit.
    function automatic logic [31:0] crc32_bit_step(input logic [31:0] crc, input logic din);
        logic fb;
        fb = crc[31] ^ din;
        return {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h00000000);
    endfunction

endpackage

// File: rtl/crc32_serial_check_if.sv
// Framed serial bit stream: one bit per in_valid cycle, with frame delimiters.
interface crc32_serial_check_if;
    logic in_valid;
    logic in_bit;
    logic in_sof;
    logic in_eof;

    modport master (output in_valid, output in_bit, output in_sof, output in_eof);
    modport slave  (input  in_valid, input  in_bit, input  in_sof, input  in_eof);
endinterface

// File: rtl/crc32_serial_check.sv
// Bit-serial CRC32 frame checker. Runs the MPEG-2 CRC over payload plus
// the transmitted FCS; a clean frame leaves a zero residue. Reports one
// status set per frame (CRC match, length, alignment, abort) with a
// one-cycle done pulse.
module crc32_serial_check
    import crc32_pkg::*;
#(
    parameter int MIN_BITS   = 64,
    parameter int MAX_BITS   = 12144,
    parameter int CNT_W      = 14,
    parameter int BYTE_ALIGN = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    crc32_serial_check_if.slave    rx,
    output logic                   done,
    output logic                   crc_ok,
    output logic                   len_err,
    output logic                   align_err,
    output logic                   aborted,
    output logic [CNT_W-1:0]       bit_count,
    output logic [31:0]            crc
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);

    rx_state_e          state_r, state_next_s;
    logic [31:0]        crc_r, base_s, crc_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic [2:0]         lo_r, lo_next_s;
    logic               accept_s;

    logic               report_s, rep_ok_s, rep_abort_s, rep_len_s, rep_align_s;
    logic [CNT_W-1:0]   rep_cnt_s;
    logic [2:0]         rep_lo_s;

    logic               done_r, crc_ok_r, len_err_r, align_err_r, aborted_r;
    logic [CNT_W-1:0]   bit_count_r;

    // Datapath: next CRC and counters assuming the current bit is accepted.
    always_comb begin
        base_s     = rx.in_sof ? CRC32_INIT : crc_r;
        crc_next_s = crc32_bit_step(base_s, rx.in_bit);
        if (rx.in_sof) begin
            cnt_next_s = CNT_W'(1);
        end else if (cnt_r == CNT_SAT) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
        // Low bits wrap freely so alignment survives counter saturation.
        lo_next_s = rx.in_sof ? 3'd1 : lo_r + 3'd1;
        accept_s  = rx.in_valid && ((state_r == ST_RX) || rx.in_sof);
    end

    // Control: next state and which frame (if any) is reported this cycle.
    always_comb begin
        state_next_s = state_r;
        report_s     = 1'b0;
        rep_cnt_s    = cnt_next_s;
        rep_lo_s     = lo_next_s;
        rep_ok_s     = (crc_next_s == CRC32_RESIDUE);
        rep_abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx.in_valid && rx.in_sof) begin
                    if (rx.in_eof) begin
                        report_s     = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RX;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RX: begin
                if (rx.in_valid && rx.in_eof) begin
                    report_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (rx.in_valid && rx.in_sof) begin
                    // Old frame is reported as-is; this bit opens the new one.
                    report_s     = 1'b1;
                    rep_cnt_s    = cnt_r;
                    rep_lo_s     = lo_r;
                    rep_ok_s     = 1'b0;
                    rep_abort_s  = 1'b1;
                    state_next_s = ST_RX;
                end else begin
                    state_next_s = ST_RX;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        rep_len_s   = (rep_cnt_s < CNT_MIN) || (rep_cnt_s > CNT_MAX);
        rep_align_s = (BYTE_ALIGN != 0) && (rep_lo_s != 3'd0);
    end

    // State, CRC/counter registers and registered frame status.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            crc_r       <= CRC32_INIT;
            cnt_r       <= '0;
            lo_r        <= 3'd0;
            done_r      <= 1'b0;
            crc_ok_r    <= 1'b0;
            len_err_r   <= 1'b0;
            align_err_r <= 1'b0;
            aborted_r   <= 1'b0;
            bit_count_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                crc_r <= crc_next_s;
                cnt_r <= cnt_next_s;
                lo_r  <= lo_next_s;
            end
            done_r <= report_s;
            if (report_s) begin
                crc_ok_r    <= rep_ok_s;
                len_err_r   <= rep_len_s;
                align_err_r <= rep_align_s;
                aborted_r   <= rep_abort_s;
                bit_count_r <= rep_cnt_s;
            end
        end
    end

    assign done      = done_r;
    assign crc_ok    = crc_ok_r;
    assign len_err   = len_err_r;
    assign align_err = align_err_r;
    assign aborted   = aborted_r;
    assign bit_count = bit_count_r;
    assign crc       = crc_r;

endmodule

// File: tb/tb_crc32_serial_check.sv
// Directed self-checking bench for crc32_serial_check.
module tb_crc32_serial_check;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        done, crc_ok, len_err, align_err, aborted;
    logic [13:0] bit_count;
    logic [31:0] crc;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_saved;
    bit stall_en = 1'b0;

    logic [103:0] good_f;
    logic [103:0] bad_f;

    crc32_serial_check_if rx_if ();

    crc32_serial_check dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx_if),
        .done      (done),
        .crc_ok    (crc_ok),
        .len_err   (len_err),
        .align_err (align_err),
        .aborted   (aborted),
        .bit_count (bit_count),
        .crc       (crc)
    );

    always #5 clk = ~clk;

    // Count done pulses for the no-report checks.
    always @(posedge clk) if (done === 1'b1) done_seen++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic s, input logic e);
        rx_if.in_valid = v;
        rx_if.in_bit   = b;
        rx_if.in_sof   = s;
        rx_if.in_eof   = e;
        tick();
        rx_if.in_valid = 1'b0;
        rx_if.in_bit   = 1'b0;
        rx_if.in_sof   = 1'b0;
        rx_if.in_eof   = 1'b0;
    endtask

    task automatic send_bits(input logic [103:0] f, input int lo, input int hi, input bit eof_last);
        for (int i = lo; i <= hi; i++) begin
            int g;
            g = stall_en ? int'($urandom_range(0, 2)) : 0;
            repeat (g) drive(1'b0, 1'b1, 1'b1, 1'b1);
            drive(1'b1, f[103-i], i == 0, eof_last && (i == hi));
        end
    endtask

    task automatic send_gen(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, (i % 3) == 0, i == 0, i == n - 1);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input bit use_ok, input logic ok,
                              input logic len, input logic al, input logic ab, input int cnt);
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (use_ok) chk({tag, "_crc_ok"}, 32'(crc_ok), 32'(ok));
        chk({tag, "_len_err"}, 32'(len_err), 32'(len));
        chk({tag, "_align_err"}, 32'(align_err), 32'(al));
        chk({tag, "_aborted"}, 32'(aborted), 32'(ab));
        chk({tag, "_bit_count"}, 32'(bit_count), 32'(cnt));
    endtask

    initial begin
        good_f = {72'h313233343536373839, 32'h0376E6E7};
        bad_f  = good_f;
        bad_f[103-17] = ~bad_f[103-17];

        rx_if.in_valid = 1'b0;
        rx_if.in_bit   = 1'b0;
        rx_if.in_sof   = 1'b0;
        rx_if.in_eof   = 1'b0;

        // Reset state, with a live sof bit that reset must override.
        reset_n = 1'b0;
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_crc", crc, 32'hFFFFFFFF);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", {28'd0, crc_ok, len_err, align_err, aborted}, 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Good frame.
        send_bits(good_f, 0, 103, 1'b1);
        chk_status("good", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 104);
        chk("good_residue", crc, 32'h00000000);
        tick();
        chk("good_done_one_cycle", 32'(done), 32'd0);
        chk("good_status_held", 32'(crc_ok), 32'd1);

        // Bits without sof in IDLE are ignored.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("idle_ignore_crc", crc, 32'h00000000);
        chk("idle_ignore_done", 32'(done), 32'd0);

        // Corrupt frame.
        send_bits(bad_f, 0, 103, 1'b1);
        chk_status("bad", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 104);
        chk("bad_crc_nonzero", 32'(crc !== 32'h00000000), 32'd1);

        // Short, misaligned frame.
        send_gen(60);
        chk_status("short60", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 60);

        // One-bit frame.
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk_status("onebit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);

        // Oversize frame: counter saturates.
        send_gen(12152);
        chk_status("long", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12145);

        // Abort at bit 40, then a complete good frame.
        send_bits(good_f, 0, 39, 1'b0);
        send_bits(good_f, 0, 0, 1'b0);
        chk_status("abort", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 40);
        send_bits(good_f, 1, 103, 1'b1);
        chk_status("after_abort", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 104);

        // Stalled frame, then a back-to-back frame with no bubble.
        stall_en = 1'b1;
        send_bits(good_f, 0, 103, 1'b1);
        stall_en = 1'b0;
        chk_status("stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 104);
        send_bits(good_f, 0, 103, 1'b1);
        chk_status("b2b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 104);

        // Reset mid-frame at bit 50.
        send_bits(good_f, 0, 49, 1'b0);
        done_saved = done_seen;
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        reset_n = 1'b1;
        chk("midrst_crc", crc, 32'hFFFFFFFF);
        chk("midrst_flags", {27'd0, done, crc_ok, len_err, align_err, aborted}, 32'd0);
        chk("midrst_bit_count", 32'(bit_count), 32'd0);
        repeat (3) tick();
        chk("midrst_no_done", 32'(done_seen), 32'(done_saved));
        send_bits(good_f, 0, 103, 1'b1);
        chk_status("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
